// File: rtl/systolic_pkg.sv
//------------------------------------------------------------------------------
// Module   : systolic_pkg
// Purpose  : Constants and the drain FSM state type for the systolic-array output path.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package systolic_pkg;

    localparam int N_LANES = 32;
    localparam int PSUM_W  = 17;
    localparam int SEL_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        SEND = 2'd2
    } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/psum_drain_seq_if.sv
//------------------------------------------------------------------------------
// Module   : psum_drain_seq_if
// Purpose  : Bundles the mux select/data pair and the valid/ready output stream.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface psum_drain_seq_if #(
    parameter int DATA_W = systolic_pkg::PSUM_W,
    parameter int SEL_W  = systolic_pkg::SEL_W
);

    logic [DATA_W-1:0] mux_y;
    logic [SEL_W-1:0]  mux_sel;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    // master: the drain sequencer; slave: the mux plus the output buffer.
    modport master (
        input  mux_y,
        input  out_ready,
        output mux_sel,
        output out_data,
        output out_valid,
        output out_last
    );

    modport slave (
        output mux_y,
        output out_ready,
        input  mux_sel,
        input  out_data,
        input  out_valid,
        input  out_last
    );

endinterface

`default_nettype wire

// File: rtl/psum_drain_seq.sv
//------------------------------------------------------------------------------
// Module   : psum_drain_seq
// Purpose  : Steps the partial-sum mux select through every lane and streams each
//            captured word out over a valid/ready handshake.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module psum_drain_seq
    import systolic_pkg::drain_state_t, systolic_pkg::IDLE,
           systolic_pkg::CAPT, systolic_pkg::SEND;
#(
    parameter int N_LANES = systolic_pkg::N_LANES,
    parameter int DATA_W  = systolic_pkg::PSUM_W,
    parameter int SEL_W   = systolic_pkg::SEL_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic             abort,
    psum_drain_seq_if.master      bus,
    output logic                  busy,
    output logic                  done
);

    localparam logic [SEL_W-1:0] c_last_sel = SEL_W'(N_LANES - 1);

    drain_state_t      r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_done;

    // sel and data only move on a handshake or at frame start to keep mux toggling low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_sel   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CAPT;
                    end
                end
                CAPT: begin
                    if (abort) begin
                        r_sel   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_data  <= bus.mux_y;
                        r_valid <= 1'b1;
                        r_last  <= (r_sel == c_last_sel);
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_sel   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_last) begin
                            r_sel   <= '0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_sel   <= r_sel + SEL_W'(1);
                            r_state <= CAPT;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_sel   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mux_sel   = r_sel;
    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.out_last  = r_last;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

`default_nettype wire

// File: doc/psum_drain_seq.md
Name: psum_drain_seq

Overview:
Downstream drain sequencer for the 32-way partial-sum output mux of the low-power systolic array.
- On a start pulse it steps the mux select through all lanes and captures each 17-bit mux output.
- It presents each captured word as a valid/ready stream toward the output buffer.
- It holds sel and out_data stable between steps so downstream logic sees minimal toggling.

Parameters:
N_LANES, 32, number of mux inputs drained per frame (2..256)
DATA_W, 17, width of mux output y and of out_data
SEL_W, 8, width of the sel bus driven to the mux

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to drain one frame; ignored unless idle
abort  input  1  synchronous abandon of the current frame
mux_y  input  DATA_W  combinational output y of the 32:1 mux
mux_sel  output  SEL_W  registered select driven to the mux sel input
out_data  output  DATA_W  captured lane value
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  high with out_valid on lane N_LANES-1
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset is asynchronous and active-low: rst_n low forces, immediately:
  - state=IDLE
  - mux_sel=0, out_data=0
  - out_valid=0, out_last=0, busy=0, done=0
- IDLE: done=0.
  - start=1 -> mux_sel<=0, state<=CAPT.
- CAPT: mux_y is stable (mux_sel registered last edge). On this edge:
  - out_data<=mux_y, out_valid<=1
  - out_last<=(mux_sel==N_LANES-1)
  - state<=SEND
- SEND: out_valid, out_data and out_last are held constant until out_ready=1.
  - Handshake at the edge where out_valid&out_ready=1:
    - not last: mux_sel<=mux_sel+1, out_valid<=0, out_last<=0, state<=CAPT.
    - last: out_valid<=0, out_last<=0, mux_sel<=0, done<=1, state<=IDLE.
- Throughput: one word per 2 cycles minimum (CAPT, SEND); out_ready stalls extend SEND.
- Latency: start edge -> first out_valid high after 2 edges.
- mux_sel never exceeds N_LANES-1 and never wraps mid-frame.
- mux_sel changes only on a handshake or at frame start (low-power requirement).
- start while busy: ignored, no queuing.
- start and abort together in IDLE: abort wins, stay IDLE.
- abort in CAPT or SEND, including the same cycle as a handshake: next edge state<=IDLE, out_valid<=0, out_last<=0, mux_sel<=0, done stays 0; the word is dropped.
- out_ready while out_valid=0: ignored.
- rst_n asserted mid-frame: all outputs return to reset values asynchronously. The frame is lost and no done is issued.
- Data is passed through unmodified (no sign handling, truncation or arithmetic).

Decomposition:
- Shared package (systolic_pkg) holds:
  - constants N_LANES=32, PSUM_W=17, SEL_W=8
  - state enum drain_state_t {IDLE, CAPT, SEND}
- No sub-module is needed. The FSM, the lane counter and the output register stay in one module. The 32:1 mux is instantiated beside this block, not inside it.

Test Plan:
- Reset then start, out_ready=1, lane i mux_y=i*3+1 -> 32 words 1,4,...,94 in order, 2 cycles apart; out_last only on word 94; done pulse one cycle after, busy low.
- out_ready=0 for 5 cycles on lane 7 -> out_data=22 and mux_sel=7 held stable for all 5 cycles; accepted on first ready cycle, next word 25.
- start pulsed again on lane 10 mid-frame -> no effect; frame completes with exactly 32 words and one done.
- abort asserted during SEND of lane 12 with out_ready=1 -> word not counted, out_valid=0 next cycle, mux_sel=0, no done; a following start drains all 32 lanes from lane 0.
- rst_n low for 1 cycle during lane 20 -> outputs zero immediately, state IDLE; no spurious out_valid after release.
- Random mux_y values (17-bit, including 17'h1FFFF and 0) -> out_data matches the mux input selected by mux_sel bit-exact for every lane.
